// File: rtl/seq_alu.sv
// seq_alu: registered, parametrised ALU with a start/busy/done handshake.
//
// Operands and opcode are captured when a start request is accepted. Single-cycle
// operations register their result one cycle later; MUL runs a WIDTH-step shift-add
// sequence first and then registers its result through the same EXEC cycle.
//
// Handshake: start is accepted only when the block is IDLE and not in its done cycle
// (state == IDLE && !done). From the acceptance edge busy is high until the cycle
// before done. done is a one-cycle pulse, and z/flags are valid from that cycle and
// hold until the next done. There is no queueing: start while busy or during done is
// dropped, and a/b/op are don't-care once the request has been accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (aborts any operation, no done pulse)
//   start      request, sampled only in IDLE outside the done cycle
//   a, b       operands, WIDTH bits
//   op         opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 SLT
//   busy       operation in progress
//   done       one-cycle completion pulse
//   z          result register
//   ov         signed overflow (ADD/SUB) or nonzero high product half (MUL)
//   cout       carry / no-borrow / last bit shifted out
//   sign       z[WIDTH-1]
//   zero       z == 0
//   state_dbg  current FSM state (0 IDLE, 1 EXEC, 2 MUL)
module seq_alu #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             ov,
    output logic             cout,
    output logic             sign,
    output logic             zero,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    state_t               state, state_nxt;
    logic                 accept;
    logic [WIDTH-1:0]     a_r, b_r;
    logic [2:0]           op_r;
    logic [SHW-1:0]       cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   partial;

    logic [WIDTH:0]       add_w, sub_w, shl_w;
    logic [WIDTH-1:0]     res;
    logic                 res_ov, res_cout;

    // The done cycle blocks acceptance so a caller holding start across done
    // does not re-issue the same request.
    assign accept    = (state == IDLE) && start && !done;
    assign busy      = (state != IDLE);
    assign sign      = z[WIDTH-1];
    assign zero      = (z == '0);
    assign state_dbg = state;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. MUL hands over to EXEC after its last step so that every
    // opcode registers its result in the same state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (op == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC:    state_nxt = IDLE;
            MUL: begin
                if (cnt == SHW'(WIDTH - 1)) begin
                    state_nxt = EXEC;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One shift-add step: add a shifted by the current bit position if that bit of b is set.
    assign partial = b_r[cnt] ? ({{WIDTH{1'b0}}, a_r} << cnt) : '0;

    // Result and flag computation from the captured operands.
    always_comb begin
        res      = '0;
        res_ov   = 1'b0;
        res_cout = 1'b0;
        add_w    = {1'b0, a_r} + {1'b0, b_r};
        sub_w    = {1'b0, a_r} + {1'b0, ~b_r} + (WIDTH+1)'(1);
        // The extra top bit catches the last bit shifted out; it is 0 for amount 0.
        shl_w    = {1'b0, a_r} << b_r[SHW-1:0];
        case (op_r)
            OP_ADD: begin
                res      = add_w[WIDTH-1:0];
                res_cout = add_w[WIDTH];
                res_ov   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_w[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_SUB: begin
                res      = sub_w[WIDTH-1:0];
                res_cout = sub_w[WIDTH];
                res_ov   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sub_w[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_AND: res = a_r & b_r;
            OP_OR:  res = a_r | b_r;
            OP_XOR: res = a_r ^ b_r;
            OP_SHL: begin
                res      = shl_w[WIDTH-1:0];
                res_cout = shl_w[WIDTH];
            end
            OP_MUL: begin
                res    = acc[WIDTH-1:0];
                res_ov = |acc[2*WIDTH-1:WIDTH];
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
            default: res = '0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            op_r <= '0;
            cnt  <= '0;
            acc  <= '0;
            z    <= '0;
            ov   <= 1'b0;
            cout <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r  <= a;
                        b_r  <= b;
                        op_r <= op;
                        cnt  <= '0;
                        acc  <= '0;
                    end
                end
                MUL: begin
                    acc <= acc + partial;
                    cnt <= cnt + SHW'(1);
                end
                EXEC: begin
                    z    <= res;
                    ov   <= res_ov;
                    cout <= res_cout;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         busy, done, ov, cout, sign, zero;
  logic [W-1:0] z;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .z(z), .ov(ov), .cout(cout),
    .sign(sign), .zero(zero), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // Driver: issue one request, scramble inputs after acceptance, wait for done.
  // lat = edges from acceptance to done (-1 on timeout); busy_ok = busy high every
  // cycle before done and low in the done cycle.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output logic busy_ok);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    a  = W'($urandom_range(0, 255));
    b  = W'($urandom_range(0, 255));
    busy_ok = (busy === 1'b1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (z !== 8'h00) $display("FAIL reset_z got %h want 00", z); else n_pass++;
    n_checks++; if ({ov, cout, sign, zero} !== 4'b0001)
      $display("FAIL reset_flags got ov/cout/sign/zero=%b want 0001", {ov, cout, sign, zero}); else n_pass++;
    n_checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state got %0d want 0", state_dbg); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    int lat; logic bok;
    do_op(3'b000, 8'hA9, 8'h83, lat, bok);
    n_checks++; if (lat !== 1) $display("FAIL add_latency got %0d want 1", lat); else n_pass++;
    n_checks++; if (bok !== 1'b1) $display("FAIL add_busy got %b want 1", bok); else n_pass++;
    n_checks++; if (z !== 8'h2C) $display("FAIL add_z got %h want 2c", z); else n_pass++;
    n_checks++; if ({ov, cout, sign, zero} !== 4'b1100)
      $display("FAIL add_flags got ov/cout/sign/zero=%b want 1100", {ov, cout, sign, zero}); else n_pass++;
    do_op(3'b001, 8'hA9, 8'h83, lat, bok);
    n_checks++; if (z !== 8'h26) $display("FAIL sub1_z got %h want 26", z); else n_pass++;
    n_checks++; if ({ov, cout} !== 2'b01) $display("FAIL sub1_flags got ov/cout=%b want 01", {ov, cout}); else n_pass++;
    do_op(3'b001, 8'h00, 8'h01, lat, bok);
    n_checks++; if (z !== 8'hFF) $display("FAIL sub2_z got %h want ff", z); else n_pass++;
    n_checks++; if ({ov, cout, sign, zero} !== 4'b0010)
      $display("FAIL sub2_flags got ov/cout/sign/zero=%b want 0010", {ov, cout, sign, zero}); else n_pass++;
  endtask

  task automatic test_mul();
    int lat; logic bok;
    do_op(3'b110, 8'h69, 8'h43, lat, bok);
    n_checks++; if (lat !== W + 1) $display("FAIL mul1_latency got %0d want %0d", lat, W + 1); else n_pass++;
    n_checks++; if (bok !== 1'b1) $display("FAIL mul1_busy got %b want 1", bok); else n_pass++;
    n_checks++; if (z !== 8'h7B) $display("FAIL mul1_z got %h want 7b", z); else n_pass++;
    n_checks++; if ({ov, cout} !== 2'b10) $display("FAIL mul1_flags got ov/cout=%b want 10", {ov, cout}); else n_pass++;
    do_op(3'b110, 8'h0F, 8'h11, lat, bok);
    n_checks++; if (z !== 8'hFF) $display("FAIL mul2_z got %h want ff", z); else n_pass++;
    n_checks++; if (ov !== 1'b0) $display("FAIL mul2_ov got %b want 0", ov); else n_pass++;
  endtask

  task automatic test_logic_shift();
    int lat; logic bok;
    do_op(3'b101, 8'hE9, 8'h03, lat, bok);
    n_checks++; if (z !== 8'h48) $display("FAIL shl_z got %h want 48", z); else n_pass++;
    n_checks++; if ({ov, cout} !== 2'b01) $display("FAIL shl_flags got ov/cout=%b want 01", {ov, cout}); else n_pass++;
    do_op(3'b101, 8'hE9, 8'h00, lat, bok);
    n_checks++; if ({z, cout} !== {8'hE9, 1'b0}) $display("FAIL shl0 got z=%h cout=%b want e9/0", z, cout); else n_pass++;
    do_op(3'b111, 8'hE9, 8'h53, lat, bok);
    n_checks++; if (z !== 8'h01) $display("FAIL slt_z got %h want 01", z); else n_pass++;
    do_op(3'b111, 8'h53, 8'hE9, lat, bok);
    n_checks++; if (z !== 8'h00) $display("FAIL slt_rev_z got %h want 00", z); else n_pass++;
    do_op(3'b010, 8'hE9, 8'h16, lat, bok);
    n_checks++; if ({z, zero} !== {8'h00, 1'b1}) $display("FAIL and got z=%h zero=%b want 00/1", z, zero); else n_pass++;
    do_op(3'b011, 8'hE9, 8'h16, lat, bok);
    n_checks++; if (z !== 8'hFF) $display("FAIL or_z got %h want ff", z); else n_pass++;
    do_op(3'b100, 8'hE9, 8'h16, lat, bok);
    n_checks++; if (z !== 8'hFF) $display("FAIL xor_z got %h want ff", z); else n_pass++;
  endtask

  // start held through the done cycle is dropped once, then accepted on the next edge
  task automatic test_back_to_back();
    int lat; logic bok;
    do_op(3'b000, 8'h01, 8'h02, lat, bok);
    start = 1'b1; op = 3'b100; a = 8'hF0; b = 8'hFF;
    @(posedge clk); #1;
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL b2b_done_cycle got busy/done=%b want 00", {busy, done}); else n_pass++;
    n_checks++; if (z !== 8'h03) $display("FAIL b2b_hold_z got %h want 03", z); else n_pass++;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({done, z} !== {1'b1, 8'h0F}) $display("FAIL b2b_result got done=%b z=%h want 1/0f", done, z); else n_pass++;
  endtask

  task automatic test_ignore_while_busy();
    int dones = 0;
    int first = -1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 8'h69; b = 8'h43;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h01;
      end
      @(posedge clk); #1;
      if (i == 3) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (first < 0) first = i;
      end
    end
    n_checks++; if (dones !== 1) $display("FAIL busy_ignore_dones got %0d want 1", dones); else n_pass++;
    n_checks++; if (first !== W + 1) $display("FAIL busy_ignore_latency got %0d want %0d", first, W + 1); else n_pass++;
    n_checks++; if ({z, ov} !== {8'h7B, 1'b1}) $display("FAIL busy_ignore_z got z=%h ov=%b want 7b/1", z, ov); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    int lat; logic bok;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL abort_busy_done got %b want 00", {busy, done}); else n_pass++;
    n_checks++; if ({z, zero, ov} !== {8'h00, 1'b1, 1'b0}) $display("FAIL abort_z got z=%h zero=%b ov=%b want 00/1/0", z, zero, ov); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones !== 0) $display("FAIL abort_no_done got %0d want 0", dones); else n_pass++;
    do_op(3'b000, 8'h10, 8'h20, lat, bok);
    n_checks++; if ({lat, z} !== {32'sd1, 8'h30}) $display("FAIL abort_next_add got lat=%0d z=%h want 1/30", lat, z); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_logic_shift();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
